dt1_wb_stage: RTL and testbench

Write-back stage for the dt1 RV32I pipeline, sitting between the data-memory (MEM) stage and the three-ported register file. It registers the MEM-stage results, extracts and extends load data, selects the write-back value, and drives the register file's write port (we3/a3/wd3). It also exposes the write-back value for forwarding and keeps a 64-bit retired-instruction counter.

---
 rtl/dt1_wb_stage.sv | 95 +++++++++
 tb/tb_dt1_wb_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dt1_wb_stage.sv
// dt1_wb_stage: RV32I write-back stage - registers MEM results, extracts load data,
// drives the register-file write port and counts retired instructions.
module dt1_wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            mem_valid,
    input  logic            mem_regwrite,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_resultsrc,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_pcplus4,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_result,
    output logic [63:0]     instret
);
    logic            valid_q;
    logic            regwrite_q;
    logic [4:0]      rd_q;
    logic [1:0]      resultsrc_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] pcplus4_q;
    logic [XLEN-1:0] rdata_q;
    logic [63:0]     cnt_q;
    logic [1:0]      off;
    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] result;

    // Flush only clears valid; the payload is don't-care and simply holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            rd_q        <= '0;
            resultsrc_q <= '0;
            funct3_q    <= '0;
            alu_q       <= '0;
            pcplus4_q   <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= mem_valid;
            regwrite_q  <= mem_regwrite;
            rd_q        <= mem_rd;
            resultsrc_q <= mem_resultsrc;
            funct3_q    <= mem_funct3;
            alu_q       <= mem_alu_result;
            pcplus4_q   <= mem_pcplus4;
            rdata_q     <= mem_rdata;
            if (mem_valid)
                cnt_q <= cnt_q + 64'd1;
        end
    end

    assign off     = alu_q[1:0];
    assign shifted = rdata_q >> {off, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = off[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        load_data = rdata_q;
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b001:  load_data = {{(XLEN-16){half_v[15]}}, half_v};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_v};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_v};
            default: load_data = rdata_q;
        endcase
    end

    assign result    = (resultsrc_q == 2'b01) ? load_data :
                       (resultsrc_q == 2'b10) ? pcplus4_q : alu_q;
    assign wd3       = result;
    assign wb_result = result;
    assign we3       = valid_q & regwrite_q & (rd_q != 5'd0);
    assign a3        = rd_q;
    assign wb_rd     = rd_q;
    assign wb_valid  = valid_q;
    assign instret   = cnt_q;
endmodule

// File: tb/tb_dt1_wb_stage.sv
// tb_dt1_wb_stage: directed self-checking bench for the dt1 write-back stage.
module tb_dt1_wb_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        mem_valid, mem_regwrite;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_resultsrc;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_pcplus4, mem_rdata;
    logic        we3, wb_valid;
    logic [4:0]  a3, wb_rd;
    logic [31:0] wd3, wb_result;
    logic [63:0] instret;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_cnt = 0;

    dt1_wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .mem_resultsrc(mem_resultsrc), .mem_funct3(mem_funct3),
        .mem_alu_result(mem_alu_result), .mem_pcplus4(mem_pcplus4),
        .mem_rdata(mem_rdata), .we3(we3), .a3(a3), .wd3(wd3),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_result(wb_result),
        .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] rs, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] rdata);
        mem_valid = v; mem_regwrite = rw; mem_rd = rd; mem_resultsrc = rs;
        mem_funct3 = f3; mem_alu_result = alu; mem_pcplus4 = pc4; mem_rdata = rdata;
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        #2;
        n_cmp++; if (we3 !== 1'b0) begin n_err++; $display("FAIL reset_we3 got %b want 0", we3); end
        n_cmp++; if (wd3 !== 32'h0) begin n_err++; $display("FAIL reset_wd3 got %h want 0", wd3); end
        n_cmp++; if (instret !== 64'h0) begin n_err++; $display("FAIL reset_instret got %h want 0", instret); end
        step();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (we3 !== 1'b0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL idle_we3 got %b/%b want 0/0", we3, wb_valid); end
    endtask

    task automatic test_alu();
        drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b010, 32'h1234, 32'h40, 32'hDEADBEEF);
        step();
        exp_cnt++;
        n_cmp++; if (we3 !== 1'b1 || a3 !== 5'd3) begin n_err++; $display("FAIL alu_we3_a3 got %b/%0d want 1/3", we3, a3); end
        n_cmp++; if (wd3 !== 32'h1234) begin n_err++; $display("FAIL alu_wd3 got %h want 00001234", wd3); end
        n_cmp++; if (instret !== 64'd1) begin n_err++; $display("FAIL alu_instret got %0d want 1", instret); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [8]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011, 3'b100};
        logic [1:0]  off [8] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2, 2'd3, 2'd1, 2'd0};
        logic [31:0] exp [8] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01,
                                 32'h80FF7F01, 32'hFFFF80FF, 32'h80FF7F01, 32'h00000001};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 5'd7, 2'b01, f3[i], {30'h400, off[i]}, 32'h200, 32'h80FF7F01);
            step();
            exp_cnt++;
            n_cmp++; if (wd3 !== exp[i]) begin n_err++; $display("FAIL load%0d_f3=%b_off=%0d got %h want %h", i, f3[i], off[i], wd3, exp[i]); end
        end
        n_cmp++; if (instret !== exp_cnt) begin n_err++; $display("FAIL load_instret got %0d want %0d", instret, exp_cnt); end
    endtask

    task automatic test_jal();
        drive(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h888, 32'h104, 32'h0);
        step();
        exp_cnt++;
        n_cmp++; if (we3 !== 1'b1 || wd3 !== 32'h104) begin n_err++; $display("FAIL jal got we3=%b wd3=%h want 1/00000104", we3, wd3); end
        drive(1'b1, 1'b1, 5'd0, 2'b10, 3'b000, 32'h888, 32'h104, 32'h0);
        step();
        exp_cnt++;
        n_cmp++; if (we3 !== 1'b0) begin n_err++; $display("FAIL jal_x0_we3 got %b want 0", we3); end
        n_cmp++; if (wb_result !== 32'h104) begin n_err++; $display("FAIL jal_x0_result got %h want 00000104", wb_result); end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'hABCD, 32'h300, 32'h0);
        step();
        exp_cnt++;
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd12, 2'b10, 3'b000, 32'h5555, 32'h999, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (wd3 !== 32'hABCD || a3 !== 5'd9 || we3 !== 1'b1)
                begin n_err++; $display("FAIL stall%0d got wd3=%h a3=%0d we3=%b want 0000abcd/9/1", i, wd3, a3, we3); end
            n_cmp++; if (instret !== exp_cnt) begin n_err++; $display("FAIL stall%0d_instret got %0d want %0d", i, instret, exp_cnt); end
        end
        stall = 1'b0;
    endtask

    task automatic test_flush();
        flush = 1'b1; stall = 1'b1;
        step();
        n_cmp++; if (wb_valid !== 1'b0 || we3 !== 1'b0) begin n_err++; $display("FAIL flush_stall got valid=%b we3=%b want 0/0", wb_valid, we3); end
        stall = 1'b0;
        step();
        n_cmp++; if (instret !== exp_cnt || wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_instret got %0d/%b want %0d/0", instret, wb_valid, exp_cnt); end
        flush = 1'b0;
        step();
        exp_cnt++;
        n_cmp++; if (wb_valid !== 1'b1 || wd3 !== 32'h999 || a3 !== 5'd12) begin n_err++; $display("FAIL post_flush got %b/%h/%0d want 1/00000999/12", wb_valid, wd3, a3); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0);
        step();
        stall = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        n_cmp++; if (we3 !== 1'b0 || wd3 !== 32'h0 || instret !== 64'h0 || wb_valid !== 1'b0)
            begin n_err++; $display("FAIL mid_reset got we3=%b wd3=%h cnt=%0d valid=%b want all 0", we3, wd3, instret, wb_valid); end
        step();
        rst = 1'b1; stall = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        step();
        n_cmp++; if (we3 !== 1'b0 || instret !== 64'h0) begin n_err++; $display("FAIL post_reset_idle got we3=%b cnt=%0d want 0/0", we3, instret); end
    endtask

    task automatic test_wrap();
        dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0);
        step();
        n_cmp++; if (instret !== 64'h0) begin n_err++; $display("FAIL wrap got %h want 0", instret); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_jal();
        test_stall();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
